alu_sequencer: RTL and testbench

//  Initiator for the shared 64-bit ALU datapath. Accepts one instruction word per start pulse.

---
 rtl/cpu_pkg.sv | 91 +++++++++
 rtl/alu_sequencer_if.sv | 41 ++++
 rtl/alu_operand_sel.sv | 78 +++++++
 rtl/alu_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU sequencer slice.
//  - Opcode encodings (identical to the ALU's own opcode encoding)
//  - Instruction field positions and field/immediate helpers
//  - Sequencer FSM state encoding
//  - Operand-class enum and opcode classifier
package cpu_pkg;

    localparam int REG_AW = 4;    // GPR address width (16 registers)
    localparam int IMM_W  = 19;   // immediate field width
    localparam int DATA_W = 32;

    // Instruction field LSB positions: [31:27]op [26:23]ra [22:19]rb [18:15]rc [18:0]C
    localparam int OP_LSB = 27;
    localparam int RA_LSB = 23;
    localparam int RB_LSB = 19;
    localparam int RC_LSB = 15;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_EX   = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        RTYPE  = 3'd0,
        IMM    = 3'd1,
        UNARY  = 3'd2,
        MULDIV = 3'd3,
        MEM    = 3'd4,
        BAD    = 3'd5
    } op_class_t;

    function automatic logic [4:0] f_op(input logic [31:0] ir);
        return ir[OP_LSB +: 5];
    endfunction

    function automatic logic [REG_AW-1:0] f_ra(input logic [31:0] ir);
        return ir[RA_LSB +: REG_AW];
    endfunction

    function automatic logic [REG_AW-1:0] f_rb(input logic [31:0] ir);
        return ir[RB_LSB +: REG_AW];
    endfunction

    function automatic logic [REG_AW-1:0] f_rc(input logic [31:0] ir);
        return ir[RC_LSB +: REG_AW];
    endfunction

    function automatic logic [DATA_W-1:0] sext_c(input logic [31:0] ir);
        return {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    endfunction

    // ldi sits in MEM: it shares the address-style operand map with ld/st/br.
    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t cls;
        cls = BAD;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:        cls = RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:               cls = IMM;
            OP_NEG, OP_NOT:                         cls = UNARY;
            OP_MUL, OP_DIV:                         cls = MULDIV;
            OP_LD, OP_LDI, OP_ST, OP_BR:            cls = MEM;
            default:                                cls = BAD;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bus bundle between the sequencer and its environment (front end, GPR file,
// HI/LO registers, ALU).
//  master : the sequencer's view (drives control, RF addresses/writes, ALU operands)
//  slave  : the environment's view
interface alu_sequencer_if;

    logic                          start;
    logic [31:0]                   instr;
    logic                          busy;
    logic                          done;
    logic                          err;
    logic [cpu_pkg::REG_AW-1:0]    rf_raddr_a;
    logic [cpu_pkg::REG_AW-1:0]    rf_raddr_b;
    logic [31:0]                   rf_rdata_a;
    logic [31:0]                   rf_rdata_b;
    logic                          rf_we;
    logic [cpu_pkg::REG_AW-1:0]    rf_waddr;
    logic [31:0]                   rf_wdata;
    logic                          hi_we;
    logic                          lo_we;
    logic [31:0]                   hi_wdata;
    logic [31:0]                   lo_wdata;
    logic [31:0]                   alu_a;
    logic [31:0]                   alu_b;
    logic [4:0]                    alu_op;
    logic [63:0]                   alu_result;
    logic [31:0]                   ea_out;

    modport master (
        input  start, instr, rf_rdata_a, rf_rdata_b, alu_result,
        output busy, done, err, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               hi_we, lo_we, hi_wdata, lo_wdata, alu_a, alu_b, alu_op, ea_out
    );

    modport slave (
        output start, instr, rf_rdata_a, rf_rdata_b, alu_result,
        input  busy, done, err, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               hi_we, lo_we, hi_wdata, lo_wdata, alu_a, alu_b, alu_op, ea_out
    );

endinterface

// File: rtl/alu_operand_sel.sv
// Combinational operand selector: classifies the latched instruction and forms
// the GPR read addresses and the ALU a/b operands from IR, read data and sext(C).
// Configuration macro: R0_BASE_ZERO_EN -- when defined, ld/ldi/st with rb==0 use
// a base of 0 instead of R[0] (absolute addressing).
// Ports:
//  ir                 in   latched instruction word
//  rf_rdata_a/b       in   GPR read data (ports A/B)
//  op_class           out  decoded operand class
//  raddr_a/raddr_b    out  GPR read addresses (0 when a port is unused)
//  alu_a/alu_b        out  ALU operands (0 for unsupported opcodes)
module alu_operand_sel
    import cpu_pkg::*;
(
    input  logic [31:0]        ir,
    input  logic [31:0]        rf_rdata_a,
    input  logic [31:0]        rf_rdata_b,
    output op_class_t          op_class,
    output logic [REG_AW-1:0]  raddr_a,
    output logic [REG_AW-1:0]  raddr_b,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b
);

    logic [4:0]        op;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [REG_AW-1:0] rc;
    logic [31:0]       imm;
    logic              base_zero;

    assign op       = f_op(ir);
    assign ra       = f_ra(ir);
    assign rb       = f_rb(ir);
    assign rc       = f_rc(ir);
    assign imm      = sext_c(ir);
    assign op_class = classify(op);

`ifdef R0_BASE_ZERO_EN
    // br is deliberately excluded: only the load/store family gets absolute addressing.
    assign base_zero = ((op == OP_LD) || (op == OP_LDI) || (op == OP_ST)) && (rb == '0);
`else
    assign base_zero = 1'b0;
`endif

    always_comb begin
        raddr_a = '0;
        raddr_b = '0;
        alu_a   = '0;
        alu_b   = '0;
        case (op_class)
            RTYPE: begin
                raddr_a = rb;
                raddr_b = rc;
                alu_a   = rf_rdata_a;
                alu_b   = rf_rdata_b;
            end
            IMM, MEM: begin
                raddr_a = rb;
                alu_a   = base_zero ? '0 : rf_rdata_a;
                alu_b   = imm;
            end
            UNARY: begin
                // neg/not operate on b; a is held at 0
                raddr_b = rb;
                alu_b   = rf_rdata_b;
            end
            MULDIV: begin
                raddr_a = ra;
                raddr_b = rb;
                alu_a   = rf_rdata_a;
                alu_b   = rf_rdata_b;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one instruction per start pulse, reads operands from the
// GPR file, drives the shared 64-bit ALU, captures the result in Z and retires it
// to a GPR, HI/LO, or the effective-address port.
// Sequence: IDLE -> RD (addresses out) -> EX (operands out, Z captured) -> WB (done).
// Configuration macro: R0_BASE_ZERO_EN (handled in alu_operand_sel).
// Ports:
//  clock   in   system clock, rising edge
//  reset   in   synchronous active-high reset; aborts any instruction in flight
//  bus     master modport of alu_sequencer_if (start/instr, busy/done/err,
//          GPR read/write, HI/LO write, ALU operands/result, ea_out)
module alu_sequencer
    import cpu_pkg::*;
(
    input logic             clock,
    input logic             reset,
    alu_sequencer_if.master bus
);

    state_t            state_reg;
    logic [31:0]       ir_reg;
    logic [63:0]       z_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;
    logic              rf_we_reg;
    logic              hi_we_reg;
    logic              lo_we_reg;

    op_class_t         op_class;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;
    logic [REG_AW-1:0] sel_raddr_a;
    logic [REG_AW-1:0] sel_raddr_b;
    logic              writes_gpr;
    logic              in_ex;

    alu_operand_sel u_operand_sel (
        .ir         (ir_reg),
        .rf_rdata_a (bus.rf_rdata_a),
        .rf_rdata_b (bus.rf_rdata_b),
        .op_class   (op_class),
        .raddr_a    (sel_raddr_a),
        .raddr_b    (sel_raddr_b),
        .alu_a      (sel_a),
        .alu_b      (sel_b)
    );

    // ldi is the only MEM-class op that also retires to a GPR.
    assign writes_gpr = (op_class == RTYPE) || (op_class == IMM) ||
                        (op_class == UNARY) || (f_op(ir_reg) == OP_LDI);
    assign in_ex      = (state_reg == ST_EX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            ir_reg    <= '0;
            z_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            rf_we_reg <= 1'b0;
            hi_we_reg <= 1'b0;
            lo_we_reg <= 1'b0;
        end else begin
            // retire strobes are single-cycle unless re-armed below
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            rf_we_reg <= 1'b0;
            hi_we_reg <= 1'b0;
            lo_we_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        ir_reg    <= bus.instr;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_RD;
                    end
                end
                ST_RD: begin
                    // read data returns one cycle after the address, i.e. during EX
                    state_reg <= ST_EX;
                end
                ST_EX: begin
                    // unsupported ops leave Z (and everything derived from it) untouched
                    if (op_class != BAD) begin
                        z_reg <= bus.alu_result;
                    end
                    done_reg  <= 1'b1;
                    err_reg   <= (op_class == BAD);
                    rf_we_reg <= writes_gpr;
                    hi_we_reg <= (op_class == MULDIV);
                    lo_we_reg <= (op_class == MULDIV);
                    state_reg <= ST_WB;
                end
                ST_WB: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.err        = err_reg;
    assign bus.rf_raddr_a = sel_raddr_a;
    assign bus.rf_raddr_b = sel_raddr_b;
    assign bus.rf_we      = rf_we_reg;
    assign bus.rf_waddr   = f_ra(ir_reg);
    assign bus.rf_wdata   = z_reg[31:0];
    assign bus.hi_we      = hi_we_reg;
    assign bus.lo_we      = lo_we_reg;
    assign bus.hi_wdata   = z_reg[63:32];
    assign bus.lo_wdata   = z_reg[31:0];
    assign bus.ea_out     = z_reg[31:0];

    // ALU operands are only presented during EX so the shared ALU sees zeros otherwise.
    assign bus.alu_op     = in_ex ? f_op(ir_reg) : 5'd0;
    assign bus.alu_a      = in_ex ? sel_a : 32'd0;
    assign bus.alu_b      = in_ex ? sel_b : 32'd0;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: GPR file and ALU are modelled here, and
// each instruction's expected operands and retire values are predicted from the
// instruction-level operand map and opcode semantics.
module tb_alu_sequencer;
    import cpu_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    alu_sequencer_if bus();

    alu_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] regs [16];
    logic [63:0] last_z;

    typedef struct {
        logic [4:0]  op;
        logic [3:0]  ra;
        logic [3:0]  pa;
        logic [3:0]  pb;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] z;
        logic        gpr;
        logic        hilo;
        logic        err;
        logic        ea;
    } exp_t;

    // Reference ALU: opcode semantics on two 32-bit operands, 64-bit result.
    function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0]        r;
        logic [4:0]         s;
        logic [63:0]        aa;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        s  = b[4:0];
        aa = {a, a};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            OP_ADD, OP_ADDI, OP_LD, OP_LDI, OP_ST, OP_BR: r = {32'h0, a + b};
            OP_SUB:           r = {32'h0, a - b};
            OP_AND, OP_ANDI:  r = {32'h0, a & b};
            OP_OR, OP_ORI:    r = {32'h0, a | b};
            OP_SHR:           r = {32'h0, a >> s};
            OP_SHRA:          r = {32'h0, $signed(a) >>> s};
            OP_SHL:           r = {32'h0, a << s};
            OP_ROR:           r = {32'h0, 32'(aa >> s)};
            OP_ROL:           r = {32'h0, 32'((aa << s) >> 32)};
            OP_MUL:           r = sa * sb;
            OP_DIV:           r = (b == 32'h0) ? {32'h0, 32'hFFFF_FFFF} : {a % b, a / b};
            OP_NEG:           r = {32'h0, 32'h0 - b};
            OP_NOT:           r = {32'h0, ~b};
            default:          r = 64'hDEAD_BEEF_0BAD_F00D;
        endcase
        return r;
    endfunction

    always @(posedge clock) begin
        bus.rf_rdata_a <= regs[bus.rf_raddr_a];
        bus.rf_rdata_b <= regs[bus.rf_raddr_b];
    end

    always_comb bus.alu_result = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);

    function automatic logic [31:0] mk_r(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'h0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [18:0] c);
        return {op, ra, rb, c};
    endfunction

    // Instruction-level prediction from the operand map.
    function automatic exp_t predict(input logic [31:0] ins, input logic [63:0] prev_z);
        exp_t        e;
        logic [3:0]  rb;
        logic [3:0]  rc;
        logic [31:0] c;
        logic [31:0] base;
        e.op = ins[31:27];
        e.ra = ins[26:23];
        rb   = ins[22:19];
        rc   = ins[18:15];
        c    = {{13{ins[18]}}, ins[18:0]};
        base = regs[rb];
`ifdef R0_BASE_ZERO_EN
        if (rb == 4'd0 && (e.op == OP_LD || e.op == OP_LDI || e.op == OP_ST)) base = 32'h0;
`endif
        e.pa = 4'd0; e.pb = 4'd0; e.a = 32'h0; e.b = 32'h0;
        e.gpr = 1'b0; e.hilo = 1'b0; e.err = 1'b0; e.ea = 1'b0;
        case (e.op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: begin
                e.pa = rb; e.pb = rc; e.a = regs[rb]; e.b = regs[rc]; e.gpr = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                e.pa = rb; e.a = regs[rb]; e.b = c; e.gpr = 1'b1;
            end
            OP_NEG, OP_NOT: begin
                e.pb = rb; e.b = regs[rb]; e.gpr = 1'b1;
            end
            OP_MUL, OP_DIV: begin
                e.pa = e.ra; e.pb = rb; e.a = regs[e.ra]; e.b = regs[rb]; e.hilo = 1'b1;
            end
            OP_LDI: begin
                e.pa = rb; e.a = base; e.b = c; e.gpr = 1'b1; e.ea = 1'b1;
            end
            OP_LD, OP_ST: begin
                e.pa = rb; e.a = base; e.b = c; e.ea = 1'b1;
            end
            OP_BR: begin
                e.pa = rb; e.a = regs[rb]; e.b = c; e.ea = 1'b1;
            end
            default: e.err = 1'b1;
        endcase
        e.z = e.err ? prev_z : alu_model(e.op, e.a, e.b);
        return e;
    endfunction

    // Raises start right now (caller sits #1 after an edge with the FSM idle at the
    // next edge) and follows the instruction through RD, EX, WB and the idle cycle.
    task automatic run_instr(input logic [31:0] ins);
        exp_t e;
        e = predict(ins, last_z);
        bus.start = 1'b1;
        bus.instr = ins;
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.instr = $urandom;
        checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            errors++;
            $display("FAIL rd_status busy,done=%b required 10", {bus.busy, bus.done});
        end
        checks++;
        if ({bus.rf_raddr_a, bus.rf_raddr_b} !== {e.pa, e.pb}) begin
            errors++;
            $display("FAIL rd_addr got a=%0d b=%0d required a=%0d b=%0d",
                     bus.rf_raddr_a, bus.rf_raddr_b, e.pa, e.pb);
        end
        @(posedge clock); #1;
        checks++;
        if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {e.op, e.a, e.b}) begin
            errors++;
            $display("FAIL ex_operands got op=%h a=%h b=%h required op=%h a=%h b=%h",
                     bus.alu_op, bus.alu_a, bus.alu_b, e.op, e.a, e.b);
        end
        @(posedge clock); #1;
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.rf_we, bus.hi_we, bus.lo_we} !==
            {2'b11, e.err, e.gpr, e.hilo, e.hilo}) begin
            errors++;
            $display("FAIL wb_flags busy,done,err,rf_we,hi_we,lo_we=%b required %b",
                     {bus.busy, bus.done, bus.err, bus.rf_we, bus.hi_we, bus.lo_we},
                     {2'b11, e.err, e.gpr, e.hilo, e.hilo});
        end
        if (e.gpr) begin
            checks++;
            if ({bus.rf_waddr, bus.rf_wdata} !== {e.ra, e.z[31:0]}) begin
                errors++;
                $display("FAIL wb_gpr got R%0d=%h required R%0d=%h",
                         bus.rf_waddr, bus.rf_wdata, e.ra, e.z[31:0]);
            end
        end
        checks++;
        if ({bus.hi_wdata, bus.lo_wdata} !== e.z) begin
            errors++;
            $display("FAIL wb_hilo got %h_%h required %h", bus.hi_wdata, bus.lo_wdata, e.z);
        end
        if (e.ea) begin
            checks++;
            if (bus.ea_out !== e.z[31:0]) begin
                errors++;
                $display("FAIL wb_ea got %h required %h", bus.ea_out, e.z[31:0]);
            end
        end
        $display("txn instr=%h op=%02h a=%h b=%h z=%h err=%0b",
                 ins, e.op, e.a, e.b, e.z, e.err);
        last_z = e.z;
        @(posedge clock); #1;
        checks++;
        if ({bus.busy, bus.done, bus.rf_we, bus.hi_we, bus.lo_we} !== 5'b0) begin
            errors++;
            $display("FAIL idle_status busy,done,rf_we,hi_we,lo_we=%b required 00000",
                     {bus.busy, bus.done, bus.rf_we, bus.hi_we, bus.lo_we});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.instr = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.rf_we, bus.hi_we, bus.lo_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b required 000000",
                     {bus.busy, bus.done, bus.err, bus.rf_we, bus.hi_we, bus.lo_we});
        end
        checks++;
        if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.ea_out, bus.hi_wdata, bus.lo_wdata} !== 165'b0) begin
            errors++;
            $display("FAIL reset_data op=%h a=%h b=%h ea=%h z=%h_%h required all zero",
                     bus.alu_op, bus.alu_a, bus.alu_b, bus.ea_out, bus.hi_wdata, bus.lo_wdata);
        end
        last_z = 64'h0;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_directed();
        regs[2] = 32'd5; regs[3] = 32'd7;
        run_instr(mk_r(OP_ADD, 4'd1, 4'd2, 4'd3));
        checks++;
        if (bus.rf_wdata !== 32'd12) begin
            errors++;
            $display("FAIL add_value got %h required 0000000c", bus.rf_wdata);
        end
        regs[4] = 32'h0001_0000; regs[5] = 32'h0001_0000;
        run_instr(mk_r(OP_MUL, 4'd4, 4'd5, 4'd0));
        checks++;
        if ({bus.hi_wdata, bus.lo_wdata} !== 64'h1_0000_0000) begin
            errors++;
            $display("FAIL mul_value got %h_%h required 00000001_00000000",
                     bus.hi_wdata, bus.lo_wdata);
        end
        regs[2] = 32'h100;
        run_instr(mk_i(OP_ADDI, 4'd1, 4'd2, 19'h7FFFF));
        checks++;
        if (bus.rf_wdata !== 32'hFF) begin
            errors++;
            $display("FAIL addi_sext got %h required 000000ff", bus.rf_wdata);
        end
        regs[0] = 32'h50;
        run_instr(mk_i(OP_LD, 4'd6, 4'd0, 19'd4));
        checks++;
`ifdef R0_BASE_ZERO_EN
        if (bus.ea_out !== 32'h4) begin
            errors++;
            $display("FAIL ld_r0_base got %h required 00000004", bus.ea_out);
        end
`else
        if (bus.ea_out !== 32'h54) begin
            errors++;
            $display("FAIL ld_r0_base got %h required 00000054", bus.ea_out);
        end
`endif
    endtask

    task automatic test_bad_op();
        int dones;
        dones = 0;
        regs[2] = 32'd1; regs[3] = 32'd2;
        bus.start = 1'b1;
        bus.instr = mk_r(5'b11111, 4'd1, 4'd2, 4'd3);
        @(posedge clock); #1;
        // second start pulse while in RD must be ignored
        bus.instr = mk_r(OP_ADD, 4'd1, 4'd2, 4'd3);
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(posedge clock); #1;
        checks++;
        if ({bus.done, bus.err, bus.rf_we, bus.hi_we, bus.lo_we} !== 5'b11000) begin
            errors++;
            $display("FAIL bad_op_wb done,err,rf_we,hi_we,lo_we=%b required 11000",
                     {bus.done, bus.err, bus.rf_we, bus.hi_we, bus.lo_we});
        end
        checks++;
        if ({bus.hi_wdata, bus.lo_wdata} !== last_z) begin
            errors++;
            $display("FAIL bad_op_z_hold got %h_%h required %h",
                     bus.hi_wdata, bus.lo_wdata, last_z);
        end
        $display("txn instr=%h op=1f err=1 (start pulse in RD)", mk_r(5'b11111, 4'd1, 4'd2, 4'd3));
        repeat (8) begin
            @(posedge clock); #1;
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL ignored_start extra dones=%0d required 0", dones);
        end
    endtask

    task automatic test_reset_abort();
        int wes;
        wes = 0;
        regs[2] = 32'd5; regs[3] = 32'd7;
        bus.start = 1'b1;
        bus.instr = mk_r(OP_ADD, 4'd1, 4'd2, 4'd3);
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.rf_we, bus.hi_we, bus.lo_we} !== 5'b0) begin
            errors++;
            $display("FAIL abort_flags busy,done,rf_we,hi_we,lo_we=%b required 00000",
                     {bus.busy, bus.done, bus.rf_we, bus.hi_we, bus.lo_we});
        end
        checks++;
        if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.hi_wdata, bus.lo_wdata} !== 133'b0) begin
            errors++;
            $display("FAIL abort_data op=%h a=%h b=%h z=%h_%h required all zero",
                     bus.alu_op, bus.alu_a, bus.alu_b, bus.hi_wdata, bus.lo_wdata);
        end
        $display("txn instr=%h aborted by reset in EX", mk_r(OP_ADD, 4'd1, 4'd2, 4'd3));
        last_z = 64'h0;
        repeat (5) begin
            @(posedge clock); #1;
            if ((bus.rf_we | bus.done | bus.hi_we | bus.lo_we) === 1'b1) wes++;
        end
        checks++;
        if (wes !== 0) begin
            errors++;
            $display("FAIL abort_no_write strobes seen=%0d required 0", wes);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] op;
        for (int n = 0; n < 60; n++) begin
            for (int r = 0; r < 16; r++) regs[r] = $urandom;
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 15)] = 32'h0;
            if ($urandom_range(0, 9) < 8) op = 5'($urandom_range(0, 19));
            else op = 5'($urandom_range(20, 31));
            run_instr({op, 27'($urandom)});
        end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) regs[r] = 32'h0;
        last_z = 64'h0;
        bus.start = 1'b0;
        bus.instr = 32'h0;
        test_reset();
        test_directed();
        test_bad_op();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
